// File: rtl/fwft_arb_pkg.sv
// Shared types and helpers for the FWFT round-robin drain arbiter and related arbiters.
// Holds the arbiter state encoding and the circular priority search.
package fwft_arb_pkg;

    localparam int unsigned MAX_SRC   = 16;
    localparam int unsigned MAX_SRC_W = 4;

    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

    typedef struct packed {
        logic                 found;
        logic [MAX_SRC_W-1:0] idx;
    } rr_pick_t;

    function automatic int unsigned arb_src_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Callers zero-extend req, so searching mod MAX_SRC equals searching mod their source count.
    function automatic rr_pick_t rr_pick(input logic [MAX_SRC-1:0]   req,
                                         input logic [MAX_SRC_W-1:0] last);
        rr_pick_t             res;
        logic [MAX_SRC_W-1:0] cand;
        res = '0;
        for (int unsigned k = 1; k <= MAX_SRC; k++) begin
            cand = last + MAX_SRC_W'(k);
            if (!res.found && req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational circular priority encoder: first set req bit searching from last+1.
// Shared by the arbiters in this codebase.
module rr_priority_pick
    import fwft_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    localparam int unsigned SRC_W  = arb_src_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   last,
    output logic               found,
    output logic [SRC_W-1:0]   idx
);

    rr_pick_t res;

    always_comb begin
        res   = rr_pick(MAX_SRC'(req), MAX_SRC_W'(last));
        // Range check keeps a stray index from being reported as a grant.
        found = res.found & ({1'b0, res.idx} < (MAX_SRC_W + 1)'(NUM_SRC));
        idx   = res.idx[SRC_W-1:0];
    end

endmodule

// File: rtl/fwft_fifo_rr_drain_arb.sv
// Drains a bank of FWFT FIFO read ports into one valid/ready stream, serving sources
// round-robin in bursts of up to MAX_BURST words with one arbitration bubble between bursts.
module fwft_fifo_rr_drain_arb
    import fwft_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 16,
    localparam int unsigned SRC_W    = arb_src_w(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*DATA_W-1:0] src_rdata,
    input  logic [NUM_SRC-1:0]        src_rdata_vld,
    output logic [NUM_SRC-1:0]        src_rden,
    input  logic [NUM_SRC-1:0]        src_enable,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    output logic                      out_last,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic                      busy
);

    localparam int unsigned          CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]     LAST_CNT  = CNT_W'(MAX_BURST - 1);
    localparam logic [SRC_W-1:0]     LAST_INIT = SRC_W'(NUM_SRC - 1);

    arb_state_t        state_q, state_d;
    logic [SRC_W-1:0]  grant_q, grant_d;
    logic [SRC_W-1:0]  last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;

    logic [DATA_W-1:0] src_words [NUM_SRC];
    logic [NUM_SRC-1:0] req;
    logic              pick_found;
    logic [SRC_W-1:0]  pick_idx;
    logic              out_free;
    logic              grant_vld;
    logic              grant_en;
    logic              pop;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_words
        assign src_words[i] = src_rdata[i*DATA_W +: DATA_W];
    end

    assign req       = src_rdata_vld & src_enable;
    assign out_free  = ~out_vld | out_rdy;
    assign grant_vld = src_rdata_vld[grant_q];
    assign grant_en  = src_enable[grant_q];
    assign busy      = (state_q == ARB_BURST);

    rr_priority_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .req   (req),
        .last  (last_grant_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        pop          = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_d      = pick_idx;
                    last_grant_d = pick_idx;
                    burst_cnt_d  = '0;
                    state_d      = ARB_BURST;
                end
            end
            ARB_BURST: begin
                pop = grant_vld & grant_en & out_free & ~rst;
                if (pop) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
                // Backpressure alone never ends a burst; only count, empty or disable do.
                if (!grant_vld || !grant_en || (pop && burst_cnt_q == LAST_CNT)) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        src_rden = '0;
        if (pop) begin
            src_rden[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_INIT;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_src  <= '0;
            out_last <= 1'b0;
        end else if (pop) begin
            out_vld  <= 1'b1;
            out_data <= src_words[grant_q];
            out_src  <= grant_q;
            out_last <= (burst_cnt_q == LAST_CNT);
        end else if (out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fwft_fifo_rr_drain_arb.sv
// Directed bench for fwft_fifo_rr_drain_arb: queue-modelled FWFT sources, hand-derived expectations.
module tb_fwft_fifo_rr_drain_arb;

    localparam int unsigned NS = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned MB = 4;
    localparam int unsigned SW = 2;

    typedef struct packed {
        logic [SW-1:0] src;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [NS*DW-1:0] src_rdata;
    logic [NS-1:0]    src_rdata_vld;
    logic [NS-1:0]    src_rden;
    logic [NS-1:0]    src_enable;
    logic [DW-1:0]    out_data;
    logic [SW-1:0]    out_src;
    logic             out_last;
    logic             out_vld;
    logic             out_rdy;
    logic             busy;

    logic [DW-1:0]    fq [NS][$];
    beat_t            got [$];
    logic [NS-1:0]    snap;
    int               n_chk  = 0;
    int               n_fail = 0;
    int               n_pop  = 0;

    always #5 clk = ~clk;

    fwft_fifo_rr_drain_arb #(
        .NUM_SRC   (NS),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .src_rdata     (src_rdata),
        .src_rdata_vld (src_rdata_vld),
        .src_rden      (src_rden),
        .src_enable    (src_enable),
        .out_data      (out_data),
        .out_src       (out_src),
        .out_last      (out_last),
        .out_vld       (out_vld),
        .out_rdy       (out_rdy),
        .busy          (busy)
    );

    function automatic logic [DW-1:0] wd(input int s, input int j);
        return DW'(32'hA000 + s * 256 + j);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NS; i++) begin
            src_rdata_vld[i]      = (fq[i].size() != 0);
            src_rdata[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endtask

    task automatic push(input int s, input int first, input int n);
        for (int j = 0; j < n; j++) fq[s].push_back(wd(s, first + j));
        refresh();
    endtask

    task automatic flush();
        for (int i = 0; i < NS; i++) fq[i].delete();
        refresh();
    endtask

    // One clock: sample handshakes before the edge, then retire popped words from the queues.
    task automatic tick();
        logic [DW-1:0] tmp;
        #1;
        snap = src_rden;
        if (out_vld && out_rdy) got.push_back(beat_t'({out_src, out_data, out_last}));
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (snap[i]) begin
                if (fq[i].size() != 0) tmp = fq[i].pop_front();
                n_pop++;
            end
        end
        refresh();
        #1;
    endtask

    logic [20:0] exp_vld;
    int          exp_s [10];
    int          exp_j [10];

    initial begin
        exp_vld = 21'b0_1111_0_1111_0_1111_0_1111_0;
        exp_s   = '{3, 3, 3, 3, 1, 1, 1, 1, 3, 3};
        exp_j   = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5};

        // Reset state, with source 0 already presenting words
        rst = 1'b1; out_rdy = 1'b1; src_enable = '1; src_rdata = '0; src_rdata_vld = '0;
        refresh();
        tick();
        push(0, 0, 3);
        tick();
        chk("rst_out_vld", 32'(out_vld), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_src", 32'(out_src), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rden", 32'(src_rden), 0);

        // Single source, three words
        rst = 1'b0;
        #1;
        chk("t1_idle_rden", 32'(src_rden), 0);
        tick();
        chk("t1_busy", 32'(busy), 1);
        chk("t1_rden", 32'(src_rden), 32'b0001);
        chk("t1_bubble_vld", 32'(out_vld), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t1_vld%0d", k), 32'(out_vld), 1);
            chk($sformatf("t1_data%0d", k), 32'(out_data), 32'(wd(0, k)));
            chk($sformatf("t1_src%0d", k), 32'(out_src), 0);
            chk($sformatf("t1_last%0d", k), 32'(out_last), 0);
        end
        chk("t1_rden_empty", 32'(src_rden), 0);
        chk("t1_busy_hold", 32'(busy), 1);
        tick();
        chk("t1_vld_end", 32'(out_vld), 0);
        chk("t1_busy_end", 32'(busy), 0);
        chk("t1_count", 32'(got.size()), 3);

        // Source 3 runs empty after two words; source 0 is served next
        got.delete();
        push(3, 0, 2);
        push(0, 10, 1);
        tick();
        chk("t6_rden3", 32'(src_rden), 32'b1000);
        tick();
        tick();
        tick();
        chk("t6_idle_busy", 32'(busy), 0);
        tick();
        chk("t6_busy0", 32'(busy), 1);
        chk("t6_rden0", 32'(src_rden), 32'b0001);
        tick();
        tick();
        chk("t6_count", 32'(got.size()), 3);
        chk("t6_beat0", 32'(got[0]), 32'({2'd3, wd(3, 0), 1'b0}));
        chk("t6_beat1", 32'(got[1]), 32'({2'd3, wd(3, 1), 1'b0}));
        chk("t6_beat2", 32'(got[2]), 32'({2'd0, wd(0, 10), 1'b0}));

        // Backpressure mid-burst: out_rdy 1,0,0,1
        got.delete();
        n_pop = 0;
        push(1, 0, 3);
        tick();
        chk("t3_rden_start", 32'(src_rden), 32'b0010);
        tick();
        chk("t3_data0", 32'(out_data), 32'(wd(1, 0)));
        out_rdy = 1'b0;
        #1;
        chk("t3_rden_bp0", 32'(src_rden), 0);
        tick();
        chk("t3_hold_data0", 32'(out_data), 32'(wd(1, 0)));
        chk("t3_hold_vld0", 32'(out_vld), 1);
        chk("t3_hold_busy", 32'(busy), 1);
        chk("t3_rden_bp1", 32'(src_rden), 0);
        tick();
        chk("t3_hold_data1", 32'(out_data), 32'(wd(1, 0)));
        chk("t3_rden_bp2", 32'(src_rden), 0);
        out_rdy = 1'b1;
        #1;
        chk("t3_rden_resume", 32'(src_rden), 32'b0010);
        tick();
        chk("t3_data1", 32'(out_data), 32'(wd(1, 1)));
        tick();
        chk("t3_data2", 32'(out_data), 32'(wd(1, 2)));
        tick();
        chk("t3_vld_end", 32'(out_vld), 0);
        chk("t3_busy_end", 32'(busy), 0);
        chk("t3_pops", 32'(n_pop), 3);
        chk("t3_accepted", 32'(got.size()), 3);
        for (int k = 0; k < 3; k++) chk($sformatf("t3_beat%0d", k), 32'(got[k].data), 32'(wd(1, k)));

        // Enable mask 1010 with all sources full; then disable source 3 mid-burst
        got.delete();
        src_enable = 4'b1010;
        for (int s = 0; s < NS; s++) push(s, 0, 8);
        tick();
        chk("t4_first_grant", 32'(src_rden), 32'b1000);
        for (int k = 0; k < 5; k++) tick();
        chk("t4_second_grant", 32'(src_rden), 32'b0010);
        for (int k = 0; k < 5; k++) tick();
        chk("t4_third_grant", 32'(src_rden), 32'b1000);
        tick();
        tick();
        chk("t4_cnt2_rden", 32'(src_rden), 32'b1000);
        src_enable = 4'b0010;
        #1;
        chk("t4_disable_rden", 32'(src_rden), 0);
        chk("t4_disable_busy", 32'(busy), 1);
        tick();
        chk("t4_exit_busy", 32'(busy), 0);
        tick();
        chk("t4_regrant1", 32'(src_rden), 32'b0010);
        src_enable = 4'b0000;
        #1;
        chk("t4_off_rden", 32'(src_rden), 0);
        tick();
        chk("t4_count", 32'(got.size()), 10);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("t4_beat%0d", k), 32'(got[k]),
                32'({SW'(exp_s[k]), wd(exp_s[k], exp_j[k]), (k == 3 || k == 7)}));
        end
        chk("t4_left3", 32'(fq[3].size()), 2);
        chk("t4_left1", 32'(fq[1].size()), 4);
        chk("t4_left0", 32'(fq[0].size()), 8);
        chk("t4_left2", 32'(fq[2].size()), 8);
        flush();

        // Reset during a source 1 burst at burst_cnt = 2
        src_enable = 4'b0010;
        push(1, 0, 8);
        push(0, 0, 4);
        tick();
        tick();
        tick();
        chk("t5_pre_rden", 32'(src_rden), 32'b0010);
        chk("t5_pre_data", 32'(out_data), 32'(wd(1, 1)));
        rst = 1'b1;
        #1;
        chk("t5_rst_vld", 32'(out_vld), 0);
        chk("t5_rst_rden", 32'(src_rden), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_data", 32'(out_data), 0);
        src_enable = '1;
        tick();
        chk("t5_rst_rden_hold", 32'(src_rden), 0);
        rst = 1'b0;
        #1;
        chk("t5_left1", 32'(fq[1].size()), 6);
        tick();
        chk("t5_first_grant0", 32'(src_rden), 32'b0001);
        chk("t5_busy", 32'(busy), 1);

        // Two saturated sources 0 and 2 from a fresh reset
        flush();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        got.delete();
        push(0, 0, 8);
        push(2, 0, 8);
        for (int k = 0; k < 21; k++) begin
            tick();
            chk($sformatf("t2_vld%0d", k), 32'(out_vld), 32'(exp_vld[20-k]));
        end
        chk("t2_busy_end", 32'(busy), 0);
        chk("t2_count", 32'(got.size()), 16);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("t2_beat%0d", k), 32'(got[k]),
                32'({SW'(((k / 4) % 2 == 0) ? 0 : 2),
                     wd(((k / 4) % 2 == 0) ? 0 : 2, (k / 8) * 4 + k % 4),
                     (k % 4 == 3)}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
